// File: rtl/uart_rx_char.sv
// uart_rx_char
//   Receives 8N1 UART frames from the board RX pin using oversampled,
//   start-edge-aligned sampling. It presents each good byte on data together
//   with a one-clock en pulse for the text-grid display.
//
// Ports
//   clk        in   1  system clock; all logic on posedge
//   reset      in   1  synchronous, active-high reset
//   rx         in   1  asynchronous serial input; idles high
//   data       out  8  last good received byte (LSB first on the line)
//   en         out  1  one-clock pulse when data has just been updated
//   frame_err  out  1  one-clock pulse when the stop bit is sampled low
//   busy       out  1  high from start-bit detect until the frame ends
//
// Parameters
//   CLK_FREQ    system clock frequency in Hz
//   BAUD        line rate in bits/s
//   OVERSAMPLE  sample ticks per bit (even, >= 8)
module uart_rx_char #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       en,
  output logic       frame_err,
  output logic       busy
);

  localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SC_W  = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [SC_W-1:0]  SC_MID   = SC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  state_t           state_r, state_n;
  logic             rx_meta_r, rx_sync_r;
  logic [DIV_W-1:0] div_cnt_r, div_cnt_n;
  logic [SC_W-1:0]  sc_r, sc_n;
  logic [2:0]       idx_r, idx_n;
  logic [7:0]       shift_r, shift_n;
  logic [7:0]       data_r, data_n;
  logic             en_r, en_n;
  logic             ferr_r, ferr_n;
  logic             busy_r, busy_n;
  logic             tick_s;

  assign tick_s    = (div_cnt_r == DIV_LAST);
  assign data      = data_r;
  assign en        = en_r;
  assign frame_err = ferr_r;
  assign busy      = busy_r;

  // Next-state and output logic for the receive FSM and its tick/bit counters.
  always_comb begin
    state_n = state_r;
    sc_n    = sc_r;
    idx_n   = idx_r;
    shift_n = shift_r;
    data_n  = data_r;
    en_n    = 1'b0;
    ferr_n  = 1'b0;
    if (tick_s) begin
      div_cnt_n = {DIV_W{1'b0}};
    end else begin
      div_cnt_n = div_cnt_r + DIV_W'(1);
    end

    case (state_r)
      ST_IDLE: begin
        if (!rx_sync_r) begin
          // Restart the divider so every later sample is phased from this edge.
          state_n   = ST_START;
          sc_n      = {SC_W{1'b0}};
          div_cnt_n = {DIV_W{1'b0}};
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick_s) begin
          if (sc_r == SC_MID) begin
            // Mid start bit: still low means a real frame, high means a glitch.
            if (!rx_sync_r) begin
              state_n = ST_DATA;
              sc_n    = {SC_W{1'b0}};
              idx_n   = 3'd0;
            end else begin
              state_n = ST_IDLE;
            end
          end else begin
            sc_n = sc_r + SC_W'(1);
          end
        end else begin
          state_n = ST_START;
        end
      end
      ST_DATA: begin
        if (tick_s) begin
          if (sc_r == SC_LAST) begin
            // Shift in from the top so the first (LSB) bit ends up in bit 0.
            shift_n = {rx_sync_r, shift_r[7:1]};
            sc_n    = {SC_W{1'b0}};
            idx_n   = idx_r + 3'd1;
            if (idx_r == 3'd7) begin
              state_n = ST_STOP;
            end else begin
              state_n = ST_DATA;
            end
          end else begin
            sc_n = sc_r + SC_W'(1);
          end
        end else begin
          state_n = ST_DATA;
        end
      end
      ST_STOP: begin
        if (tick_s) begin
          if (sc_r == SC_LAST) begin
            sc_n = {SC_W{1'b0}};
            if (rx_sync_r) begin
              data_n  = shift_r;
              en_n    = 1'b1;
              state_n = ST_IDLE;
            end else begin
              ferr_n  = 1'b1;
              state_n = ST_BREAK;
            end
          end else begin
            sc_n = sc_r + SC_W'(1);
          end
        end else begin
          state_n = ST_STOP;
        end
      end
      ST_BREAK: begin
        // Hold off until the line returns high so a held-low line is one event.
        if (rx_sync_r) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_BREAK;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    busy_n = (state_n != ST_IDLE);
  end

  // State, counter, synchroniser and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      div_cnt_r <= {DIV_W{1'b0}};
      sc_r      <= {SC_W{1'b0}};
      idx_r     <= 3'd0;
      shift_r   <= 8'h00;
      data_r    <= 8'h00;
      en_r      <= 1'b0;
      ferr_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_n;
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
      div_cnt_r <= div_cnt_n;
      sc_r      <= sc_n;
      idx_r     <= idx_n;
      shift_r   <= shift_n;
      data_r    <= data_n;
      en_r      <= en_n;
      ferr_r    <= ferr_n;
      busy_r    <= busy_n;
    end
  end

endmodule

// File: tb/tb_uart_rx_char.sv
module tb_uart_rx_char;

  localparam int BIT_CLK = 160;  // 1_600_000 / 10_000

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] data;
  logic       en;
  logic       frame_err;
  logic       busy;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int en_count = 0;
  int fe_count = 0;
  logic en_prev = 1'b0;
  logic [7:0] mon_exp;
  logic [7:0] exp_q[$];
  int en_cyc_q[$];

  uart_rx_char #(
    .CLK_FREQ  (1_600_000),
    .BAUD      (10_000),
    .OVERSAMPLE(16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .data     (data),
    .en       (en),
    .frame_err(frame_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every en pulse pops one expected byte.
  always @(negedge clk) begin
    if (en) begin
      en_count = en_count + 1;
      en_cyc_q.push_back(cyc);
      tests_run = tests_run + 1;
      if (exp_q.size() == 0) begin
        tests_failed = tests_failed + 1;
        $display("FAIL unexpected_en: got data=%02h, required no pulse", data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (data !== mon_exp) begin
          tests_failed = tests_failed + 1;
          $display("FAIL sb_data: got %02h, required %02h", data, mon_exp);
        end
      end
      if (en_prev) begin
        tests_failed = tests_failed + 1;
        $display("FAIL en_width: got en high 2 cycles, required 1");
      end
      if (frame_err) begin
        tests_failed = tests_failed + 1;
        $display("FAIL en_ferr_overlap: got both high, required exclusive");
      end
    end
    if (frame_err) fe_count = fe_count + 1;
    en_prev = en;
  end

  task automatic chk(input string name, input int act, input int exp);
    tests_run = tests_run + 1;
    if (act !== exp) begin
      tests_failed = tests_failed + 1;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic line_bit(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    line_bit(1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) line_bit(b[i], BIT_CLK);
    line_bit(stop_v, BIT_CLK);
  endtask

  typedef struct {
    logic [7:0] byte_v;
    logic       stop_v;
    int         exp_en;
    int         exp_fe;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int en0, fe0, start_c, lat;
    logic saw_busy;

    vecs[0] = '{8'h41, 1'b1, 1, 0, 8'h41};
    vecs[1] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    vecs[3] = '{8'hC3, 1'b0, 0, 1, 8'hFF};
    vecs[4] = '{8'h0A, 1'b1, 1, 0, 8'h0A};
    vecs[5] = '{8'h5A, 1'b0, 0, 1, 8'h0A};

    reset = 1'b1;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_data", int'(data), 8'h00);
    chk("reset_busy", int'(busy), 0);
    reset = 1'b0;

    // 1. Idle line
    saw_busy = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (busy || en || frame_err) saw_busy = 1'b1;
    end
    chk("idle_quiet", int'(saw_busy), 0);
    chk("idle_data", int'(data), 8'h00);

    // 2. Frame 0x41 with latency check
    en0 = en_count;
    exp_q.push_back(8'h41);
    start_c = cyc;
    send_frame(8'h41, 1'b1);
    line_bit(1'b1, 100);
    chk("f41_en_count", en_count - en0, 1);
    chk("f41_data", int'(data), 8'h41);
    lat = (en_cyc_q.size() > 0) ? en_cyc_q[en_cyc_q.size()-1] - start_c : -1;
    chk("f41_latency_ok", int'(lat >= 1515 && lat <= 1530), 1);

    // 3. Glitch shorter than half a bit
    en0 = en_count;
    saw_busy = 1'b0;
    rx = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
    end
    line_bit(1'b1, 200);
    chk("glitch_busy_rose", int'(saw_busy), 1);
    chk("glitch_busy_fell", int'(busy), 0);
    chk("glitch_no_en", en_count - en0, 0);
    chk("glitch_data", int'(data), 8'h41);

    // 4. 0x54 then a frame whose stop bit is held low 500 clk
    exp_q.push_back(8'h54);
    send_frame(8'h54, 1'b1);
    line_bit(1'b1, 50);
    en0 = en_count;
    fe0 = fe_count;
    line_bit(1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) line_bit(1'b1, BIT_CLK);
    line_bit(1'b0, BIT_CLK + 500);
    chk("brk_fe_count", fe_count - fe0, 1);
    chk("brk_busy_held", int'(busy), 1);
    chk("brk_data", int'(data), 8'h54);
    line_bit(1'b1, 200);
    chk("brk_busy_fell", int'(busy), 0);
    chk("brk_no_en", en_count - en0, 0);
    exp_q.push_back(8'h21);
    send_frame(8'h21, 1'b1);
    line_bit(1'b1, 50);
    chk("brk_recover", int'(data), 8'h21);

    // 5. Back-to-back frames with no idle gap
    en0 = en_count;
    exp_q.push_back(8'h54);
    exp_q.push_back(8'h0A);
    send_frame(8'h54, 1'b1);
    send_frame(8'h0A, 1'b1);
    line_bit(1'b1, 50);
    chk("b2b_en_count", en_count - en0, 2);
    chk("b2b_spacing",
        (en_cyc_q.size() >= 2) ? en_cyc_q[en_cyc_q.size()-1] - en_cyc_q[en_cyc_q.size()-2] : -1,
        1600);
    chk("b2b_data", int'(data), 8'h0A);

    // 6. Reset during data bit 4
    en0 = en_count;
    line_bit(1'b0, BIT_CLK);
    for (int i = 0; i < 4; i++) line_bit(1'b1, BIT_CLK);
    line_bit(1'b0, 80);
    reset = 1'b1;
    line_bit(1'b0, 3);
    reset = 1'b0;
    line_bit(1'b1, 2000);
    chk("rst_mid_no_en", en_count - en0, 0);
    chk("rst_mid_data", int'(data), 8'h00);
    chk("rst_mid_busy", int'(busy), 0);
    exp_q.push_back(8'h45);
    send_frame(8'h45, 1'b1);
    line_bit(1'b1, 50);
    chk("rst_mid_45", int'(data), 8'h45);

    // Table-driven frames
    for (int v = 0; v < 6; v++) begin
      en0 = en_count;
      fe0 = fe_count;
      if (vecs[v].stop_v) exp_q.push_back(vecs[v].byte_v);
      send_frame(vecs[v].byte_v, vecs[v].stop_v);
      line_bit(1'b1, 200);
      chk($sformatf("vec%0d_en", v), en_count - en0, vecs[v].exp_en);
      chk($sformatf("vec%0d_fe", v), fe_count - fe0, vecs[v].exp_fe);
      chk($sformatf("vec%0d_data", v), int'(data), int'(vecs[v].exp_data));
      chk($sformatf("vec%0d_busy", v), int'(busy), 0);
    end

    chk("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
